// File: rtl/arbitrated_bus.sv
// arbitrated_bus: registered lane bus. In arbitrated mode a round-robin
// arbiter grants one requesting lane at a time for at most MAX_BURST
// transfers. In direct mode the legacy one-hot lane_select drives the bus
// and multi-bit selects are flagged as contention.
module arbitrated_bus #(
    parameter  int LANES     = 6,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int OWNER_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [LANES-1:0]         lane_select,
    input  logic [LANES-1:0]         lane_req,
    input  logic [LANES*WIDTH-1:0]   lane_data,
    output logic [LANES-1:0]         lane_grant,
    output logic [WIDTH-1:0]         bus_data,
    output logic                     bus_valid,
    output logic [OWNER_W-1:0]       bus_owner,
    output logic                     contention
);

    // Burst counter must hold 0..MAX_BURST inclusive.
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Elaboration-time guards on the parameter ranges the arbiter relies on.
    if (LANES < 2) begin : g_bad_lanes
        $error("arbitrated_bus: LANES must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("arbitrated_bus: WIDTH must be >= 1");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("arbitrated_bus: MAX_BURST must be >= 1");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    // Architectural state.
    state_e             state_q;
    logic [OWNER_W-1:0] ptr_q;        // next lane to consider first
    logic [CNT_W-1:0]   cnt_q;        // transfers done in the current grant
    logic [OWNER_W-1:0] gidx_q;       // index of the granted lane
    logic [LANES-1:0]   grant_q;
    logic [WIDTH-1:0]   bus_data_q;
    logic               bus_valid_q;
    logic [OWNER_W-1:0] bus_owner_q;
    logic               contention_q;

    // Combinational helpers.
    logic [WIDTH-1:0]   lane_word [LANES];
    logic               win_found;
    logic [OWNER_W-1:0] win_idx;
    logic [LANES-1:0]   win_onehot;
    logic [OWNER_W-1:0] ptr_d;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_d;
    logic               burst_done;
    logic               grant_release;
    logic               sel_any;
    logic               sel_multi;
    logic [OWNER_W-1:0] sel_idx;

    // Unpack the flattened lane words into an indexable array.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_unpack
        assign lane_word[gi] = lane_data[gi*WIDTH +: WIDTH];
    end

    // Round-robin scan: first requester at or after ptr_q, wrapping at LANES.
    always_comb begin
        int pos;
        logic [OWNER_W-1:0] cand;
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        cand      = '0;
        for (int i = 0; i < LANES; i++) begin
            pos = int'(ptr_q) + i;
            if (pos >= LANES) begin
                pos = pos - LANES;
            end
            cand = OWNER_W'(pos);
            if (!win_found && lane_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Winner as one-hot and the pointer that follows it; only ptr wraps
    // explicitly since LANES need not be a power of two.
    always_comb begin
        win_onehot = LANES'(1) << win_idx;
        ptr_d      = (win_idx == OWNER_W'(LANES - 1)) ? '0 : win_idx + OWNER_W'(1);
    end

    // Transfer and release conditions for the current grant.
    always_comb begin
        xfer          = (state_q == S_GRANT) && (|(grant_q & lane_req));
        cnt_d         = cnt_q + CNT_W'(1);
        burst_done    = xfer && (cnt_d == CNT_W'(MAX_BURST));
        grant_release = (state_q == S_GRANT) && (!lane_req[gidx_q] || burst_done);
    end

    // Direct-mode decode: any/multiple selects and the lowest selected lane.
    always_comb begin
        sel_any   = |lane_select;
        sel_multi = (lane_select & (lane_select - LANES'(1))) != '0;
        sel_idx   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_select[OWNER_W'(i)]) begin
                sel_idx = OWNER_W'(i);
            end
        end
    end

    // Arbiter FSM and registered bus outputs.
    // NOTE: reset is asynchronous so outputs clear the moment rst rises,
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            gidx_q       <= '0;
            grant_q      <= '0;
            bus_data_q   <= '0;
            bus_valid_q  <= 1'b0;
            bus_owner_q  <= '0;
            contention_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples the pre-edge values; later assignments in this block
            // override the defaults below.
            bus_valid_q  <= 1'b0;
            contention_q <= 1'b0;

            if (mode) begin
                // Direct select: arbiter parked, ptr kept for later.
                state_q      <= S_IDLE;
                grant_q      <= '0;
                cnt_q        <= '0;
                bus_valid_q  <= sel_any;
                contention_q <= sel_multi;
                if (sel_any) begin
                    bus_data_q  <= lane_word[sel_idx];
                    bus_owner_q <= sel_idx;
                end
            end else begin
                if (xfer) begin
                    bus_data_q  <= lane_word[gidx_q];
                    bus_owner_q <= gidx_q;
                    bus_valid_q <= 1'b1;
                    cnt_q       <= cnt_d;
                end

                unique case (state_q)
                    S_IDLE: begin
                        if (win_found) begin
                            state_q <= S_GRANT;
                            grant_q <= win_onehot;
                            gidx_q  <= win_idx;
                            cnt_q   <= '0;
                            ptr_q   <= ptr_d;
                        end
                    end
                    S_GRANT: begin
                        if (grant_release) begin
                            // ptr_q already equals g+1, so the scan starts
                            // just past the releasing lane and may wrap to it.
                            cnt_q <= '0;
                            if (win_found) begin
                                grant_q <= win_onehot;
                                gidx_q  <= win_idx;
                                ptr_q   <= ptr_d;
                            end else begin
                                state_q <= S_IDLE;
                                grant_q <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                    end
                endcase
            end
        end
    end

    assign lane_grant = grant_q;
    assign bus_data   = bus_data_q;
    assign bus_valid  = bus_valid_q;
    assign bus_owner  = bus_owner_q;
    assign contention = contention_q;

    // Grant is at most one-hot and is non-zero exactly while in GRANT.
    a_grant_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));
    a_grant_state : assert property (@(posedge clk) disable iff (rst)
        ((state_q == S_GRANT) == (grant_q != '0)));

endmodule

// File: tb/tb_arbitrated_bus.sv
// Self-checking bench for arbitrated_bus: per-feature tasks with inline
// checks, plus a scoreboard of expected (owner, data) words consumed by a
// monitor whenever bus_valid is high.
module tb_arbitrated_bus;

    localparam int LANES   = 6;
    localparam int WIDTH   = 8;
    localparam int OWNER_W = 3;

    logic                   clk;
    logic                   rst;
    logic                   mode;
    logic [LANES-1:0]       lane_select;
    logic [LANES-1:0]       lane_req;
    logic [LANES*WIDTH-1:0] lane_data;
    logic [LANES-1:0]       lane_grant;
    logic [WIDTH-1:0]       bus_data;
    logic                   bus_valid;
    logic [OWNER_W-1:0]     bus_owner;
    logic                   contention;

    logic [WIDTH-1:0] word [LANES];

    typedef struct packed {
        logic [OWNER_W-1:0] owner;
        logic [WIDTH-1:0]   data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    arbitrated_bus #(.LANES(LANES), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .lane_select (lane_select),
        .lane_req    (lane_req),
        .lane_data   (lane_data),
        .lane_grant  (lane_grant),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .bus_owner   (bus_owner),
        .contention  (contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_data[i*WIDTH +: WIDTH] = word[i];
        end
    end

    // Scoreboard consumer: every valid word must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got owner=%0d data=%h, expected no valid word",
                         bus_owner, bus_data);
            end else begin
                mon_e = sb.pop_front();
                if (bus_data !== mon_e.data || bus_owner !== mon_e.owner) begin
                    bad++;
                    $display("FAIL sb_word: got owner=%0d data=%h, expected owner=%0d data=%h",
                             bus_owner, bus_data, mon_e.owner, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int owner, input logic [WIDTH-1:0] data);
        exp_t e;
        e.owner = OWNER_W'(owner);
        e.data  = data;
        sb.push_back(e);
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        mode        = 1'b0;
        lane_req    = '0;
        lane_select = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        mode        = 1'b0;
        lane_req    = '0;
        lane_select = '0;
        for (int i = 0; i < LANES; i++) word[i] = '0;
        #2;
        total++;
        if ({lane_grant, bus_data, bus_valid, bus_owner, contention} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%b data=%h valid=%b owner=%0d cont=%b, expected all 0",
                     lane_grant, bus_data, bus_valid, bus_owner, contention);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (lane_grant !== '0 || bus_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got grant=%b valid=%b, expected 0/0", lane_grant, bus_valid);
        end
    endtask

    task automatic test_single();
        reset_dut();
        word[2]  = 8'hA5;
        lane_req = 6'b000100;
        tick();
        total++;
        if (lane_grant !== 6'b000100 || bus_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_grant: got grant=%b valid=%b, expected 000100/0", lane_grant, bus_valid);
        end
        // Nine transfers cross two re-grants of the same lane without a gap.
        for (int k = 0; k < 9; k++) begin
            push(2, 8'hA5);
            tick();
            total++;
            if (bus_valid !== 1'b1 || lane_grant !== 6'b000100) begin
                bad++;
                $display("FAIL single_stream[%0d]: got valid=%b grant=%b, expected 1/000100",
                         k, bus_valid, lane_grant);
            end
        end
        lane_req = '0;
        tick();
        total++;
        if (bus_valid !== 1'b0 || lane_grant !== '0 || bus_data !== 8'hA5 || bus_owner !== 3'd2) begin
            bad++;
            $display("FAIL single_release: got valid=%b grant=%b data=%h owner=%0d, expected 0/0/a5/2",
                     bus_valid, lane_grant, bus_data, bus_owner);
        end
    endtask

    task automatic test_round_robin();
        int rr [5];
        rr = '{0, 4, 5, 0, 4};
        reset_dut();
        lane_req = 6'b110001;
        tick();
        total++;
        if (lane_grant !== 6'b000001) begin
            bad++;
            $display("FAIL rr_first_grant: got %b, expected 000001", lane_grant);
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < LANES; i++) word[i] = WIDTH'(i * 16 + k);
            push(rr[k / 4], word[rr[k / 4]]);
            tick();
            total++;
            if (bus_valid !== 1'b1 || lane_grant !== (LANES'(1) << rr[(k + 1) / 4])) begin
                bad++;
                $display("FAIL rr_step[%0d]: got valid=%b grant=%b, expected 1/%b",
                         k, bus_valid, lane_grant, LANES'(1) << rr[(k + 1) / 4]);
            end
        end
        lane_req = '0;
        tick();
    endtask

    task automatic test_early_release();
        reset_dut();
        word[1]  = 8'h21;
        word[3]  = 8'h63;
        lane_req = 6'b000010;
        tick();
        push(1, 8'h21);
        tick();
        lane_req = 6'b001010;
        push(1, 8'h21);
        tick();
        total++;
        if (bus_valid !== 1'b1 || lane_grant !== 6'b000010) begin
            bad++;
            $display("FAIL early_hold: got valid=%b grant=%b, expected 1/000010", bus_valid, lane_grant);
        end
        lane_req = 6'b001000;
        tick();
        total++;
        if (lane_grant !== 6'b001000 || bus_valid !== 1'b0 || bus_owner !== 3'd1) begin
            bad++;
            $display("FAIL early_move: got grant=%b valid=%b owner=%0d, expected 001000/0/1",
                     lane_grant, bus_valid, bus_owner);
        end
        push(3, 8'h63);
        tick();
        total++;
        if (bus_valid !== 1'b1) begin
            bad++;
            $display("FAIL early_new_owner: got valid=%b, expected 1", bus_valid);
        end
        lane_req = '0;
        tick();
        total++;
        if (lane_grant !== '0) begin
            bad++;
            $display("FAIL early_idle: got grant=%b, expected 000000", lane_grant);
        end
    endtask

    task automatic test_direct();
        reset_dut();
        word[0]     = 8'h11;
        word[1]     = 8'h5A;
        word[3]     = 8'h3C;
        word[5]     = 8'h77;
        mode        = 1'b1;
        lane_req    = '1;
        lane_select = 6'b001000;
        push(3, 8'h3C);
        tick();
        total++;
        if (bus_valid !== 1'b1 || contention !== 1'b0 || lane_grant !== '0 || bus_data !== 8'h3C) begin
            bad++;
            $display("FAIL direct_single: got valid=%b cont=%b grant=%b data=%h, expected 1/0/0/3c",
                     bus_valid, contention, lane_grant, bus_data);
        end
        lane_select = 6'b100010;
        push(1, 8'h5A);
        tick();
        total++;
        if (contention !== 1'b1 || bus_owner !== 3'd1) begin
            bad++;
            $display("FAIL direct_contention: got cont=%b owner=%0d, expected 1/1", contention, bus_owner);
        end
        lane_select = '0;
        tick();
        total++;
        if (bus_valid !== 1'b0 || bus_data !== 8'h5A || contention !== 1'b0) begin
            bad++;
            $display("FAIL direct_none: got valid=%b data=%h cont=%b, expected 0/5a/0",
                     bus_valid, bus_data, contention);
        end
        lane_select = 6'b111111;
        push(0, 8'h11);
        tick();
        total++;
        if (contention !== 1'b1) begin
            bad++;
            $display("FAIL direct_all: got cont=%b, expected 1", contention);
        end
        mode     = 1'b0;
        lane_req = '0;
        tick();
        total++;
        if (contention !== 1'b0 || bus_valid !== 1'b0 || lane_grant !== '0) begin
            bad++;
            $display("FAIL direct_exit: got cont=%b valid=%b grant=%b, expected 0/0/0",
                     contention, bus_valid, lane_grant);
        end
        lane_select = '0;
    endtask

    task automatic test_mode_switch();
        reset_dut();
        word[4]  = 8'h44;
        word[5]  = 8'h55;
        lane_req = 6'b010000;
        tick();
        push(4, 8'h44);
        tick();
        push(4, 8'h44);
        tick();
        mode        = 1'b1;
        lane_select = '0;
        tick();
        total++;
        if (lane_grant !== '0 || bus_valid !== 1'b0) begin
            bad++;
            $display("FAIL switch_abort: got grant=%b valid=%b, expected 0/0", lane_grant, bus_valid);
        end
        mode     = 1'b0;
        lane_req = 6'b110000;
        tick();
        total++;
        if (lane_grant !== 6'b100000) begin
            bad++;
            $display("FAIL switch_ptr_kept: got grant=%b, expected 100000", lane_grant);
        end
        push(5, 8'h55);
        tick();
        lane_req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        word[0]  = 8'h0F;
        word[3]  = 8'hC3;
        lane_req = 6'b001000;
        tick();
        push(3, 8'hC3);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({lane_grant, bus_data, bus_valid, bus_owner, contention} !== '0) begin
            bad++;
            $display("FAIL reset_async: got grant=%b data=%h valid=%b owner=%0d cont=%b, expected all 0",
                     lane_grant, bus_data, bus_valid, bus_owner, contention);
        end
        lane_req = 6'b001001;
        rst      = 1'b0;
        tick();
        total++;
        if (lane_grant !== 6'b000001) begin
            bad++;
            $display("FAIL reset_ptr: got grant=%b, expected 000001", lane_grant);
        end
        push(0, 8'h0F);
        tick();
        lane_req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_direct();
        test_mode_switch();
        test_reset_mid_burst();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d unconsumed words, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitrated_bus.md
# arbitrated_bus

Registered, round-robin-arbitrated successor to the combinational one-hot lane bus. Up to `LANES` producers (registers, ALU, RAM, PC) raise requests; the block grants one lane at a time, fairly and with a bounded burst length, and drives the captured word onto a registered `bus_data` with a valid strobe. A direct-select mode keeps the legacy one-hot `lane_select` behaviour for microcode that drives the bus explicitly. In direct mode it also flags select contention.

## Interface
- `LANES`, 6: number of producer lanes, ≥2.
- `WIDTH`, 8: bus word width, ≥1.
- `MAX_BURST`, 4: maximum consecutive transfers per grant, ≥1.
- `OWNER_W`, derived: max(1, $clog2(LANES)).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mode` in 1: 0 = arbitrated, 1 = direct select.
- `lane_select` in LANES: one-hot select, used only when `mode`=1.
- `lane_req` in LANES: per-lane request, used only when `mode`=0.
- `lane_data` in LANES*WIDTH: flattened lane words; lane i is bits [i*WIDTH +: WIDTH].
- `lane_grant` out LANES: registered one-hot grant, 0 when idle or in direct mode.
- `bus_data` out WIDTH: registered bus word.
- `bus_valid` out 1: `bus_data` was captured on the previous edge.
- `bus_owner` out OWNER_W: index of the lane that supplied the current `bus_data`.
- `contention` out 1: registered; the previous cycle in direct mode had more than one select bit set.

## Operation
- State is IDLE or GRANT. The block also holds a rotate pointer `ptr` (0..LANES-1) and a burst counter `cnt` (0..MAX_BURST).
- Transfer condition: in GRANT, a cycle with `lane_grant[g]` and `lane_req[g]` both high is a transfer.
  - On that edge, `bus_data` <= lane g word, `bus_owner` <= g, `bus_valid` <= 1, `cnt` += 1.
- Non-transfer edge: `bus_valid` <= 0; `bus_data` and `bus_owner` hold.
- Arbitration: the winner is the first requesting lane scanning from `ptr` upward, wrapping LANES-1 → 0.
- IDLE, `mode`=0: if any `lane_req` bit is set, go to GRANT. Set `lane_grant` to the winner, `cnt`=0, `ptr`=winner+1 mod LANES. Otherwise stay in IDLE.
- GRANT release: re-arbitrate on the edge where either
  - `lane_req[g]`=0, or
  - a transfer makes `cnt` reach MAX_BURST.
- On release:
  - A winner among the current requests takes the grant directly (no IDLE cycle); the scan starts at `ptr` = g+1.
  - The winner may be g again if g is the only requester. `cnt` resets to 0.
  - If there is no winner, go to IDLE with `lane_grant`=0.
- Direct mode (`mode`=1):
  - State is forced to IDLE, `lane_grant`=0, `cnt`=0; `ptr` holds.
  - Each edge: `bus_valid` <= |`lane_select`; `contention` <= (popcount(`lane_select`) > 1).
  - If any select bit is set, `bus_data`/`bus_owner` <= the lowest-index selected lane.
- `contention` is 0 on every edge in arbitrated mode.
- `mode` change mid-grant: on the next edge, GRANT aborts to IDLE and `lane_grant` clears.
  - If the `mode`=0 cycle before that edge held a transfer, that transfer still completes.

## Timing
- Reset values (asynchronous):
  - `lane_grant`=0, `bus_data`=0, `bus_valid`=0, `bus_owner`=0, `contention`=0.
  - State IDLE, `ptr`=0, `cnt`=0.
- Request-to-grant latency: 1 cycle (request seen at edge k, grant visible after edge k).
- Grant-to-data latency: 1 cycle (data sampled at the first edge with grant and request both high, visible after it).
- Request-to-valid latency: 2 cycles minimum.
- Sustained throughput: one word per cycle while the owner holds its request. This includes the cycle at which the grant rotates to a new requester.
- Direct mode latency: `lane_select` → `bus_data`/`bus_valid`/`contention` in 1 cycle.
- Only `ptr`'s modulo wraps; LANES need not be a power of two.
- `rst` asserted mid-burst: outputs clear immediately, without waiting for the clock edge.

## Test plan
- Reset mid-burst:
  - Stimulus: assert `rst` asynchronously between edges while lane 3 is granted.
  - Response: all outputs read 0 before the next edge; after release, lane 0 requesting wins first.
- Single requester:
  - Stimulus: `mode`=0, lane 2 requests continuously with data 0xA5.
  - Response: grant=6'b000100 after 1 edge; `bus_valid`=1, `bus_data`=0xA5, `bus_owner`=2 after 2 edges.
  - Re-grant occurs every 4 transfers with no valid gap.
- Round-robin with wrap:
  - Stimulus: lanes 0, 4, 5 request continuously, MAX_BURST=4.
  - Response: owner sequence is 0×4, 4×4, 5×4, 0×4, with an unbroken `bus_valid`.
- Early release:
  - Stimulus: lane 1 drops its request after 2 transfers while lane 3 requests.
  - Response: grant moves to lane 3 on that edge; owner sequence is 1, 1, 3…
- Direct mode:
  - `lane_select`=6'b001000 with lane 3 data 0x3C → `bus_data`=0x3C, `bus_valid`=1, `contention`=0.
  - `lane_select`=6'b100010 → `bus_owner`=1, `contention`=1.
  - `lane_select`=0 → `bus_valid`=0 and `bus_data` holds.
- Mode switch mid-grant:
  - Stimulus: set `mode`=1 during a lane 4 burst.
  - Response: `lane_grant`=0 after the next edge. After returning to `mode`=0 with lanes 4 and 5 requesting, lane 5 wins (`ptr` preserved).
